// File: rtl/msk_mod_pkg.sv
// Shared types and constants for the parametrised MSK/O-QPSK modulator.
// Holds the FSM encoding, mode codes and the half-sine table builder.
package msk_mod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int MODE_OQPSK = 0;
    localparam int MODE_MSK   = 1;

    localparam int LUT_MAX_N = 64;
    localparam int LUT_AW    = 6;
    localparam int LUT_MAX_W = 16;

    typedef logic [LUT_MAX_N-1:0][LUT_MAX_W-1:0] lut_t;

    localparam real PI = 3.14159265358979;

    // Taylor series folded into [0, pi/2]; plenty accurate for <=16-bit tables.
    function automatic real sin_approx(input real x);
        real xr;
        real term;
        real sum;
        real x2;
        xr = (x > PI / 2.0) ? (PI - x) : x;
        x2 = xr * xr;
        term = xr;
        sum = xr;
        for (int n = 1; n < 8; n++) begin
            term = -term * x2 / real'((2 * n) * (2 * n + 1));
            sum = sum + term;
        end
        return sum;
    endfunction

    // Entry k = round(amp * sin(pi*(k+0.5)/sph)), amp = 2^(w-1)-1.
    function automatic lut_t half_sine_lut(input int sph, input int w);
        lut_t lut;
        real amp;
        real v;
        lut = '0;
        amp = real'((1 << (w - 1)) - 1);
        for (int k = 0; k < sph; k++) begin
            v = amp * sin_approx(PI * (real'(k) + 0.5) / real'(sph));
            lut[LUT_AW'(k)] = LUT_MAX_W'($rtoi(v + 0.5));
        end
        return lut;
    endfunction

endpackage

// File: rtl/msk_mod_param_tick.sv
// Free-running sample-rate divider for the MSK modulator.
// Produces a one-clk tick every CLK_DIV clocks, starting from count 0.
module msk_tick_gen
    import msk_mod_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

    // Wrap at CLK_DIV-1, otherwise count up.
    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    // Divider register, synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/msk_mod_param.sv
// Parametrised MSK / O-QPSK half-sine modulator.
// Chips alternate I/Q, each shaping one SPH-sample arc offset by half an arc.
module msk_mod_param #(
    parameter int CLK_DIV = 5,
    parameter int SPH     = 10,
    parameter int W       = 4,
    parameter int MODE    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic                i_data,
    output logic                o_ready,
    output logic signed [W-1:0] o_sin_i,
    output logic signed [W-1:0] o_sin_q,
    output logic                o_sample_valid,
    output logic                o_underrun,
    output logic                o_busy
);

    import msk_mod_pkg::*;

    localparam int   HALF   = SPH / 2;
    localparam int   KW     = $clog2(SPH);
    localparam int   SW     = $clog2(HALF);
    localparam lut_t LUT    = half_sine_lut(SPH, W);

    logic tick;

    msk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick_o(tick)
    );

    state_e               state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic                 p_q, p_d;
    logic                 hold_q, hold_d;
    logic                 full_q, full_d;
    logic [1:0]           act_q, act_d;
    logic [1:0][KW-1:0]   k_q, k_d;
    logic [1:0]           pos_q, pos_d;
    logic                 last_q, last_d;
    logic signed [W-1:0]  si_q, si_d;
    logic signed [W-1:0]  sq_q, sq_d;
    logic                 sv_q, un_q;
    logic                 accept, consume, underrun, new_pos;

    function automatic logic signed [W-1:0] arc_sample(
        input logic          act,
        input logic          pos,
        input logic [KW-1:0] k
    );
        logic signed [W-1:0] mag;
        mag = $signed(LUT[LUT_AW'(k)][W-1:0]);
        if (!act) return '0;
        return pos ? mag : -mag;
    endfunction

    assign o_ready        = !full_q;
    assign accept         = i_valid && !full_q;
    assign o_sin_i        = si_q;
    assign o_sin_q        = sq_q;
    assign o_sample_valid = sv_q;
    assign o_underrun     = un_q;
    assign o_busy         = (state_q != IDLE);

    assign new_pos = (MODE == MODE_MSK)
                   ? (pos_q[p_q] ^ (hold_q == last_q))
                   : hold_q;

    // Slot sequencing, arc indices, sign history and FSM next state.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        p_d      = p_q;
        act_d    = act_q;
        k_d      = k_q;
        pos_d    = pos_q;
        last_d   = last_q;
        consume  = 1'b0;
        underrun = 1'b0;
        if (tick) begin
            if (act_q[0]) begin
                if (k_q[0] == KW'(SPH - 1)) act_d[0] = 1'b0;
                else                        k_d[0] = k_q[0] + 1'b1;
            end
            if (act_q[1]) begin
                if (k_q[1] == KW'(SPH - 1)) act_d[1] = 1'b0;
                else                        k_d[1] = k_q[1] + 1'b1;
            end
            if (s_q == SW'(HALF - 1)) begin
                s_d = '0;
                p_d = ~p_q;
            end else begin
                s_d = s_q + 1'b1;
            end
            if (s_q == '0) begin
                if (full_q) begin
                    consume     = 1'b1;
                    act_d[p_q]  = 1'b1;
                    k_d[p_q]    = '0;
                    pos_d[p_q]  = new_pos;
                    last_d      = hold_q;
                    state_d     = RUN;
                end else if (state_q != IDLE) begin
                    underrun   = 1'b1;
                    act_d[p_q] = 1'b0;
                    if (state_q == RUN)     state_d = DRAIN;
                    else if (!act_q[~p_q])  state_d = IDLE;
                end
            end
            if (state_d == IDLE) begin
                s_d = '0;
                p_d = 1'b0;
            end
        end
    end

    // Holding register and sample values presented after each tick.
    always_comb begin
        full_d = accept | (full_q & ~consume);
        hold_d = accept ? i_data : hold_q;
        si_d   = tick ? arc_sample(act_d[0], pos_d[0], k_d[0]) : si_q;
        sq_d   = tick ? arc_sample(act_d[1], pos_d[1], k_d[1]) : sq_q;
    end

    // All state, synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            p_q     <= 1'b0;
            hold_q  <= 1'b0;
            full_q  <= 1'b0;
            act_q   <= '0;
            k_q     <= '0;
            pos_q   <= '0;
            last_q  <= 1'b0;
            si_q    <= '0;
            sq_q    <= '0;
            sv_q    <= 1'b0;
            un_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            p_q     <= p_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            act_q   <= act_d;
            k_q     <= k_d;
            pos_q   <= pos_d;
            last_q  <= last_d;
            si_q    <= si_d;
            sq_q    <= sq_d;
            sv_q    <= tick;
            un_q    <= underrun;
        end
    end

endmodule
